alu_sequencer: RTL and testbench

Multi-cycle controller that owns the shared ALU datapath and runs one operation at a time. It accepts a one-hot operation plus two 32-bit operands over a start/done handshake and holds the ALU control and operands stable for the operation's latency. It also drives the DIV enable for the iteration count the divider needs, then captures the 64-bit result into HI/LO registers. It sits between the control unit and the ALU instance in the CPU datapath.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_op_check.sv | 35 +++
 rtl/alu_sequencer.sv | 130 +++++++++++++
 tb/tb_alu_sequencer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer: one-hot operation bit map,
// widths and the sequencer state encoding.
package alu_pkg;

    localparam int OP_W  = 16;
    localparam int CNT_W = 8;

    localparam int ADD = 0;
    localparam int SUB = 1;
    localparam int NEG = 2;
    localparam int MUL = 3;
    localparam int DIV = 4;
    localparam int AND = 5;
    localparam int OR  = 6;
    localparam int ROR = 7;
    localparam int ROL = 8;
    localparam int SLL = 9;
    localparam int SRA = 10;
    localparam int SRL = 11;
    localparam int NOT = 12;
    localparam int INC = 13;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/alu_op_check.sv
// Combinational legality check and latency select for a requested ALU op.
// legal: exactly one of bits 0..13 set, bits 14/15 clear.
// lat_m1: operation latency minus one, used as the initial EXEC count.
module alu_op_check
    import alu_pkg::*;
#(
    parameter int DIV_CYCLES = 34,
    parameter int MUL_CYCLES = 1
) (
    input  logic [OP_W-1:0]  op,
    output logic             legal,
    output logic [CNT_W-1:0] lat_m1
);

    logic [13:0] op_low;

    assign op_low = op[13:0];

    // One-hot test on the usable op bits; the top two bits are reserved.
    always_comb begin
        legal = (op[15:14] == 2'b00) && (op_low != 14'd0) &&
                ((op_low & (op_low - 14'd1)) == 14'd0);
    end

    // Multi-cycle ops get their configured latency, everything else one cycle.
    always_comb begin
        lat_m1 = '0;
        if (op[DIV]) begin
            lat_m1 = CNT_W'(DIV_CYCLES - 1);
        end else if (op[MUL]) begin
            lat_m1 = CNT_W'(MUL_CYCLES - 1);
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle controller for the shared ALU datapath. Runs one operation at a
// time over a start/done handshake, holds ALU controls for the op latency and
// captures the 64-bit result into z_hi/z_lo.
// Optional build macro ALU_SEQ_DIV0_EN: DIV by zero is trapped without
// enabling the divider (err=1, result cleared).
//
// state | meaning
// IDLE  | ready, ALU op held at zero (divider in reset), waiting for start
// EXEC  | ALU driven from latched op/operands, counting down the latency
// DONE  | one-cycle done pulse, result and err valid
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int DIV_CYCLES = 34,
    parameter int MUL_CYCLES = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [OP_W-1:0] op,
    input  logic [31:0]     x,
    input  logic [31:0]     y,
    output logic            ready,
    output logic            done,
    output logic            err,
    output logic [31:0]     z_hi,
    output logic [31:0]     z_lo,
    output logic [OP_W-1:0] alu_op,
    output logic [31:0]     alu_x,
    output logic [31:0]     alu_y,
    input  logic [63:0]     alu_z
);

    seq_state_t       state;
    seq_state_t       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             legal;
    logic [CNT_W-1:0] lat_m1;
    logic             div0_trap;

    alu_op_check #(
        .DIV_CYCLES (DIV_CYCLES),
        .MUL_CYCLES (MUL_CYCLES)
    ) u_op_check (
        .op     (op),
        .legal  (legal),
        .lat_m1 (lat_m1)
    );

`ifdef ALU_SEQ_DIV0_EN
    assign div0_trap = legal && op[DIV] && (y == 32'd0);
`else
    assign div0_trap = 1'b0;
`endif

    assign ready = (state == IDLE);
    assign done  = (state == DONE);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; illegal ops and trapped DIV-by-zero bypass EXEC.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (legal && !div0_trap) ? EXEC : DONE;
                end
            end
            EXEC: begin
                if (cnt == '0) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand/op latch, latency counter, result capture and error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            err    <= 1'b0;
            z_hi   <= '0;
            z_lo   <= '0;
            alu_op <= '0;
            alu_x  <= '0;
            alu_y  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        err <= !legal || div0_trap;
                        if (legal && !div0_trap) begin
                            alu_op <= op;
                            alu_x  <= x;
                            alu_y  <= y;
                            cnt    <= lat_m1;
                        end
                        if (div0_trap) begin
                            z_hi <= '0;
                            z_lo <= '0;
                        end
                    end
                end
                EXEC: begin
                    if (cnt == '0) begin
                        z_hi   <= alu_z[63:32];
                        z_lo   <= alu_z[31:0];
                        alu_op <= '0;
                        alu_x  <= '0;
                        alu_y  <= '0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Testbench for alu_sequencer paired with a behavioural ALU model.
module tb_alu_sequencer;
    import alu_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] op;
    logic [31:0] x;
    logic [31:0] y;
    logic        ready;
    logic        done;
    logic        err;
    logic [31:0] z_hi;
    logic [31:0] z_lo;
    logic [15:0] alu_op;
    logic [31:0] alu_x;
    logic [31:0] alu_y;
    logic [63:0] alu_z;

    int total = 0;
    int bad   = 0;

    alu_sequencer #(.DIV_CYCLES(34), .MUL_CYCLES(1)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .x      (x),
        .y      (y),
        .ready  (ready),
        .done   (done),
        .err    (err),
        .z_hi   (z_hi),
        .z_lo   (z_lo),
        .alu_op (alu_op),
        .alu_x  (alu_x),
        .alu_y  (alu_y),
        .alu_z  (alu_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: combinational result from the sequencer's drive.
    logic [63:0] rot_r;
    logic [63:0] rot_l;
    always_comb begin
        rot_r = {alu_x, alu_x} >> alu_y[4:0];
        rot_l = {alu_x, alu_x} << alu_y[4:0];
        alu_z = '0;
        case (alu_op)
            16'h0001: alu_z = {32'd0, alu_x + alu_y};
            16'h0002: alu_z = {32'd0, alu_x - alu_y};
            16'h0004: alu_z = {32'd0, -alu_x};
            16'h0008: alu_z = 64'(alu_x) * 64'(alu_y);
            16'h0010: alu_z = (alu_y != 0) ? {alu_x % alu_y, alu_x / alu_y}
                                            : {alu_x, 32'hFFFF_FFFF};
            16'h0020: alu_z = {32'd0, alu_x & alu_y};
            16'h0040: alu_z = {32'd0, alu_x | alu_y};
            16'h0080: alu_z = {32'd0, rot_r[31:0]};
            16'h0100: alu_z = {32'd0, rot_l[63:32]};
            16'h0200: alu_z = {32'd0, alu_x << alu_y[4:0]};
            16'h0400: alu_z = {32'd0, 32'($signed(alu_x) >>> alu_y[4:0])};
            16'h0800: alu_z = {32'd0, alu_x >> alu_y[4:0]};
            16'h1000: alu_z = {32'd0, ~alu_x};
            16'h2000: alu_z = {32'd0, alu_x + 32'd1};
            default:  alu_z = '0;
        endcase
    end

    typedef struct {
        logic [15:0] op;
        logic [31:0] x;
        logic [31:0] y;
        logic        e_err;
        logic        keep_z;
        logic [63:0] e_z;
        int          e_done;
        int          e_act;
    } vec_t;

    typedef struct {
        logic        err;
        logic [63:0] z;
    } exp_t;

    vec_t        vecs[$];
    exp_t        sb[$];
    logic [63:0] last_z = '0;

    function automatic vec_t mk(input logic [15:0] o, input logic [31:0] a,
                                input logic [31:0] b, input logic e,
                                input logic k, input logic [63:0] z,
                                input int dc, input int ac);
        vec_t v;
        v.op = o; v.x = a; v.y = b; v.e_err = e; v.keep_z = k;
        v.e_z = z; v.e_done = dc; v.e_act = ac;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("ready_timeout", {63'd0, ready}, 64'd1);
    endtask

    task automatic run_op(input vec_t v);
        int   cyc;
        int   act;
        logic seen;
        exp_t e;
        wait_ready();
        @(negedge clk);
        start = 1'b1; op = v.op; x = v.x; y = v.y;
        e.err = v.e_err;
        e.z   = v.keep_z ? last_z : v.e_z;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        cyc = 1; act = 0; seen = 1'b0;
        while (!seen && cyc < 100) begin
            if (alu_op != 16'd0) begin
                act++;
                chk("alu_op_hold", 64'(alu_op), 64'(v.op));
                chk("alu_x_hold", 64'(alu_x), 64'(v.x));
            end
            if (done) seen = 1'b1;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        chk("done_seen", {63'd0, seen}, 64'd1);
        if (seen) begin
            e = sb.pop_front();
            chk("done_cycle", 64'(cyc), 64'(v.e_done));
            chk("err", {63'd0, err}, {63'd0, e.err});
            chk("z", {z_hi, z_lo}, e.z);
            chk("alu_op_cleared", 64'(alu_op), 64'd0);
            chk("active_cycles", 64'(act), 64'(v.e_act));
            last_z = e.z;
            @(negedge clk);
            chk("ready_after", {62'd0, ready, done}, 64'd2);
            chk("err_held", {63'd0, err}, {63'd0, e.err});
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   cyc;
        int   act;
        int   ndone;
        exp_t e;

        vecs.push_back(mk(16'h0001, 32'd10, 32'd5, 1'b0, 1'b0, 64'd15, 2, 1));
        vecs.push_back(mk(16'h0010, 32'd20, 32'd5, 1'b0, 1'b0, 64'd4, 35, 34));
        vecs.push_back(mk(16'h0008, 32'd4, 32'd3, 1'b0, 1'b0, 64'd12, 2, 1));
        vecs.push_back(mk(16'h0003, 32'd1, 32'd1, 1'b1, 1'b1, 64'd0, 1, 0));
        vecs.push_back(mk(16'h8000, 32'd1, 32'd1, 1'b1, 1'b1, 64'd0, 1, 0));
        vecs.push_back(mk(16'h0000, 32'd1, 32'd1, 1'b1, 1'b1, 64'd0, 1, 0));
        vecs.push_back(mk(16'h4000, 32'd1, 32'd1, 1'b1, 1'b1, 64'd0, 1, 0));
        vecs.push_back(mk(16'h0002, 32'd5, 32'd10, 1'b0, 1'b0, 64'h0000_0000_FFFF_FFFB, 2, 1));
        vecs.push_back(mk(16'h0008, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0, 64'h0000_0001_FFFF_FFFE, 2, 1));
        vecs.push_back(mk(16'h0010, 32'd23, 32'd5, 1'b0, 1'b0, 64'h0000_0003_0000_0004, 35, 34));
        vecs.push_back(mk(16'h0080, 32'd1, 32'd1, 1'b0, 1'b0, 64'h0000_0000_8000_0000, 2, 1));
        vecs.push_back(mk(16'h0400, 32'h8000_0000, 32'd4, 1'b0, 1'b0, 64'h0000_0000_F800_0000, 2, 1));
        vecs.push_back(mk(16'h2000, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, 64'd0, 2, 1));
        vecs.push_back(mk(16'h1000, 32'd0, 32'd0, 1'b0, 1'b0, 64'h0000_0000_FFFF_FFFF, 2, 1));
        vecs.push_back(mk(16'h0200, 32'd3, 32'd4, 1'b0, 1'b0, 64'h30, 2, 1));
`ifdef ALU_SEQ_DIV0_EN
        vecs.push_back(mk(16'h0010, 32'd9, 32'd0, 1'b1, 1'b0, 64'd0, 1, 0));
`else
        vecs.push_back(mk(16'h0010, 32'd9, 32'd0, 1'b0, 1'b0, 64'h0000_0009_FFFF_FFFF, 35, 34));
`endif

        reset = 1'b1; start = 1'b0; op = '0; x = '0; y = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", {63'd0, ready}, 64'd1);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_err", {63'd0, err}, 64'd0);
        chk("rst_z", {z_hi, z_lo}, 64'd0);
        chk("rst_alu_op", 64'(alu_op), 64'd0);
        chk("rst_alu_xy", {alu_x, alu_y}, 64'd0);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            run_op(vecs[i]);
        end

        // start held high through a whole DIV: only the first is accepted.
        wait_ready();
        @(negedge clk);
        start = 1'b1; op = 16'h0010; x = 32'd100; y = 32'd7;
        e.err = 1'b0; e.z = {32'd2, 32'd14};
        sb.push_back(e);
        act = 0; ndone = 0; cyc = 0;
        for (int c = 1; c <= 35; c++) begin
            @(negedge clk);
            op = 16'h0001; x = 32'd1; y = 32'd1;
            if (alu_op != 16'd0) act++;
            if (done) begin
                ndone++;
                cyc = c;
            end
        end
        start = 1'b0;
        chk("busy_done_cycle", 64'(cyc), 64'd35);
        chk("busy_active", 64'(act), 64'd34);
        if (ndone == 1) begin
            e = sb.pop_front();
            chk("busy_z", {z_hi, z_lo}, e.z);
            last_z = e.z;
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("busy_done_count", 64'(ndone), 64'd1);

        // Reset asserted during EXEC cycle 10 abandons the DIV.
        wait_ready();
        @(negedge clk);
        start = 1'b1; op = 16'h0010; x = 32'd20; y = 32'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("pre_rst_alu_op", 64'(alu_op), 64'h10);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_alu_op", 64'(alu_op), 64'd0);
        chk("mid_rst_ready", {63'd0, ready}, 64'd1);
        chk("mid_rst_z", {z_hi, z_lo}, 64'd0);
        chk("mid_rst_done", {63'd0, done}, 64'd0);
        chk("mid_rst_xy", {alu_x, alu_y}, 64'd0);
        reset = 1'b0;
        last_z = '0;
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("mid_rst_no_done", 64'(ndone), 64'd0);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);

        // A fresh op after the abandoned one still works.
        run_op(mk(16'h0020, 32'hF0F0, 32'hFF00, 1'b0, 1'b0, 64'hF000, 2, 1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
